// File: rtl/i2c_line_mux.sv
// Registered N:1 line multiplexer with break-before-make channel switching.
// A channel change drives IDLE_VAL for GAP cycles before routing the new input.
module i2c_line_mux #(
    parameter int                      WIDTH    = 2,
    parameter int                      CHANNELS = 4,
    parameter int                      GAP      = 2,
    parameter logic [WIDTH-1:0]        IDLE_VAL = {WIDTH{1'b1}},
    parameter int                      SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel_req,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      switching,
    output logic                      sel_err
);

    localparam int CNT_W = (GAP < 1) ? 1 : $clog2(GAP + 1);

    typedef enum logic {
        ACTIVE = 1'b0,
        BREAK  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   gap_cnt;
    logic [SEL_W-1:0]   pending;
    logic               accept;
    logic               req_in_range;
    logic               req_is_new;

    function automatic logic [WIDTH-1:0] chan(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]          s);
        return bus[int'(s)*WIDTH +: WIDTH];
    endfunction

    // Handshake and status are decoded from state only, never from the data inputs.
    assign sel_ready    = (state == ACTIVE);
    assign switching    = (state == BREAK);
    assign accept       = sel_valid && sel_ready;
    assign req_in_range = (int'(sel_req) < CHANNELS);
    assign req_is_new   = req_in_range && (sel_req != cur_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ACTIVE;
            cur_sel <= '0;
            out     <= IDLE_VAL;
            gap_cnt <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            case (state)
                ACTIVE: begin
                    if (accept && !req_in_range) begin
                        sel_err <= 1'b1;
                        out     <= chan(in, cur_sel);
                    end else if (accept && req_is_new) begin
                        if (GAP > 0) begin
                            // Break first: idle the line, remember where to go.
                            pending <= sel_req;
                            gap_cnt <= CNT_W'(GAP);
                            state   <= BREAK;
                            out     <= IDLE_VAL;
                        end else begin
                            cur_sel <= sel_req;
                            out     <= chan(in, sel_req);
                        end
                    end else begin
                        out <= chan(in, cur_sel);
                    end
                end
                BREAK: begin
                    if (gap_cnt <= CNT_W'(1)) begin
                        // Last idle cycle ends here; make the new connection.
                        state   <= ACTIVE;
                        cur_sel <= pending;
                        out     <= chan(in, pending);
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                        out     <= IDLE_VAL;
                    end
                end
                default: begin
                    state <= ACTIVE;
                    out   <= IDLE_VAL;
                end
            endcase
        end
    end

endmodule
